bp_cce_gad_pipe: RTL

- Multi-cycle, parametrised Generate Auxiliary Directory block for the CCE.
- Accepts a request context, then collects directory way-group information over several beats of `lces_per_beat_p` LCE entries. It then computes the coherence control flags, the owner, and an explicit invalidation vector.
- Adds a per-request protocol mode:
  - MESI: invalidate on transfer.
  - MOESIF: downgrade the owner on reads.
- Sits between the directory read pipeline and the CCE instruction decoder/MSHR.

---
 rtl/bp_cce_pkg.sv | 24 ++
 rtl/bp_common_pkg.sv | 27 ++
 rtl/bp_cce_gad_pipe_flags.sv | 128 ++++++++++++
 rtl/bsg_encode_one_hot.sv | 33 +++
 rtl/bsg_popcount.sv | 21 ++
 rtl/bp_cce_gad_pipe.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/bp_cce_pkg.sv
// CCE-local types: protocol mode, GAD pipeline state, and a clog2 that never returns 0.
`default_nettype none

package bp_cce_pkg;

    typedef enum logic {
        e_coh_mesi   = 1'b0,
        e_coh_moesif = 1'b1
    } bp_cce_coh_mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_COMPUTE = 2'd2,
        S_DONE    = 2'd3
    } bp_cce_gad_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_common_pkg.sv
// Shared coherence-state encoding and request-type definitions used across the CCE.
`default_nettype none

package bp_common_pkg;

    // Bit 0 = shared, bit 1 = owned (responsible for supplying data), bit 2 = dirty
    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    localparam int coh_shared_bit_lp = 0;
    localparam int coh_owned_bit_lp  = 1;
    localparam int coh_dirty_bit_lp  = 2;

    typedef enum logic {
        e_lce_req_type_rd = 1'b0,
        e_lce_req_type_wr = 1'b1
    } bp_lce_cce_req_type_e;

endpackage

`default_nettype wire

// File: rtl/bp_cce_gad_pipe_flags.sv
// Combinational GAD core: coherence flags, owner pick, invalidation vector and sharer count.
`default_nettype none

module bp_cce_gad_pipe_flags
    import bp_common_pkg::*;
    import bp_cce_pkg::*;
#(
    parameter int num_lce_p      = 8,
    parameter int lce_assoc_p    = 8,
    parameter int lce_id_width_p = 4,
    localparam int lg_lce_assoc_lp = safe_clog2(lce_assoc_p),
    localparam int lg_num_lce_lp   = safe_clog2(num_lce_p),
    localparam int cnt_w_lp        = $clog2(num_lce_p + 1),
    localparam int coh_w_lp        = $bits(bp_coh_states_e)
) (
    input  logic [num_lce_p-1:0]                 hit,
    input  logic [num_lce_p*lg_lce_assoc_lp-1:0] ways,
    input  logic [num_lce_p*coh_w_lp-1:0]        states,
    input  logic [lce_id_width_p-1:0]            req_lce,
    input  logic                                 wr,
    input  logic                                 lru_dirty,
    input  logic                                 lru_excl,
    input  logic                                 moesif,
    output logic [lg_lce_assoc_lp-1:0]           req_addr_way,
    output logic [lg_lce_assoc_lp-1:0]           owner_way,
    output logic [lce_id_width_p-1:0]            owner_lce,
    output logic [num_lce_p-1:0]                 inv_vec,
    output logic [cnt_w_lp-1:0]                  sharer_count,
    output logic                                 transfer,
    output logic                                 replacement,
    output logic                                 upgrade,
    output logic                                 invalidate,
    output logic                                 downgrade,
    output logic                                 cached,
    output logic                                 cached_exclusive,
    output logic                                 cached_owned,
    output logic                                 cached_dirty
);

    logic [num_lce_p-1:0]       shared_v, owned_v, dirty_v;
    logic [num_lce_p-1:0]       others, hit_o, excl_o, owned_o, dirty_o, owner_oh;
    logic [lg_num_lce_lp-1:0]   req_idx, owner_idx;
    logic                       req_in_range, req_hit, req_shared, owner_v;
    logic [lg_lce_assoc_lp-1:0] req_way;
    logic                       mesi_inv;
    logic [num_lce_p-1:0]       mesi_vec;

    always_comb begin
        shared_v = '0;
        owned_v  = '0;
        dirty_v  = '0;
        for (int k = 0; k < num_lce_p; k++) begin
            shared_v[k] = states[k*coh_w_lp + coh_shared_bit_lp];
            owned_v[k]  = states[k*coh_w_lp + coh_owned_bit_lp];
            dirty_v[k]  = states[k*coh_w_lp + coh_dirty_bit_lp];
        end
    end

    generate
        if (lce_id_width_p > lg_num_lce_lp) begin : g_trunc
            logic unused_req_hi;
            assign unused_req_hi = ^req_lce[lce_id_width_p-1:lg_num_lce_lp];
        end
    endgenerate

    // A requester index past the last LCE excludes nobody and never hits.
    assign req_idx      = req_lce[lg_num_lce_lp-1:0];
    assign req_in_range = (int'(req_idx) < num_lce_p);
    assign others       = req_in_range ? ~(num_lce_p'(1) << req_idx) : '1;
    assign req_hit      = req_in_range & hit[req_idx];
    assign req_shared   = shared_v[req_idx];
    assign req_way      = ways[req_idx*lg_lce_assoc_lp +: lg_lce_assoc_lp];

    assign hit_o   = hit & others;
    assign excl_o  = hit & ~shared_v & others;
    assign owned_o = hit & owned_v & others;
    assign dirty_o = hit & dirty_v & others;

    assign cached           = |hit_o;
    assign cached_exclusive = |excl_o;
    assign cached_owned     = |owned_o;
    assign cached_dirty     = |dirty_o;

    assign upgrade      = wr & req_hit & req_shared;
    assign replacement  = ~upgrade & lru_excl & lru_dirty;
    assign req_addr_way = req_hit ? req_way : '0;

    // Isolate the lowest set bit so the encoder sees a true one-hot.
    assign owner_oh = owned_o & (~owned_o + num_lce_p'(1));

    bsg_encode_one_hot #(
        .width_p    (num_lce_p),
        .lo_to_hi_p (1'b1)
    ) owner_enc (
        .i      (owner_oh),
        .addr_o (owner_idx),
        .v_o    (owner_v)
    );

    assign transfer  = owner_v;
    assign owner_lce = transfer ? lce_id_width_p'(owner_idx) : '0;
    assign owner_way = transfer ? ways[owner_idx*lg_lce_assoc_lp +: lg_lce_assoc_lp] : '0;

    bsg_popcount #(
        .width_p (num_lce_p)
    ) sharer_pc (
        .i (hit_o),
        .o (sharer_count)
    );

    assign mesi_inv = wr ? cached : cached_exclusive;
    assign mesi_vec = wr ? hit_o  : excl_o;

    always_comb begin
        downgrade  = 1'b0;
        invalidate = mesi_inv;
        inv_vec    = mesi_vec;
        // MOESIF keeps the owner as a sharer on reads instead of invalidating it.
        if (moesif && !wr && transfer) begin
            downgrade  = 1'b1;
            invalidate = 1'b0;
            inv_vec    = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_encode_one_hot.sv
// One-hot to binary encoder; for multi-hot input the end selected by lo_to_hi_p wins.
`default_nettype none

module bsg_encode_one_hot
    import bp_cce_pkg::*;
#(
    parameter int width_p    = 8,
    parameter bit lo_to_hi_p = 1'b1,
    localparam int addr_w_lp = safe_clog2(width_p)
) (
    input  logic [width_p-1:0]   i,
    output logic [addr_w_lp-1:0] addr_o,
    output logic                 v_o
);

    always_comb begin
        addr_o = '0;
        if (lo_to_hi_p) begin
            for (int k = width_p - 1; k >= 0; k--) begin
                if (i[k]) addr_o = k[addr_w_lp-1:0];
            end
        end else begin
            for (int k = 0; k < width_p; k++) begin
                if (i[k]) addr_o = k[addr_w_lp-1:0];
            end
        end
    end

    assign v_o = |i;

endmodule

`default_nettype wire

// File: rtl/bsg_popcount.sv
// Population count of a bit vector.
`default_nettype none

module bsg_popcount #(
    parameter int width_p = 8,
    localparam int cnt_w_lp = $clog2(width_p + 1)
) (
    input  logic [width_p-1:0]  i,
    output logic [cnt_w_lp-1:0] o
);

    always_comb begin
        o = '0;
        for (int k = 0; k < width_p; k++) begin
            o = o + cnt_w_lp'(i[k]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bp_cce_gad_pipe.sv
// Multi-beat Generate Auxiliary Directory pipeline: accumulates way-group beats, then computes GAD results.
`default_nettype none

module bp_cce_gad_pipe
    import bp_common_pkg::*;
    import bp_cce_pkg::*;
#(
    parameter int num_lce_p       = 8,
    parameter int lce_assoc_p     = 8,
    parameter int lce_id_width_p  = 4,
    parameter int lces_per_beat_p = 2,
    localparam int num_beats_lp    = num_lce_p / lces_per_beat_p,
    localparam int lg_lce_assoc_lp = safe_clog2(lce_assoc_p),
    localparam int lg_num_lce_lp   = safe_clog2(num_lce_p),
    localparam int lg_beats_lp     = safe_clog2(num_beats_lp),
    localparam int cnt_w_lp        = $clog2(num_lce_p + 1),
    localparam int coh_w_lp        = $bits(bp_coh_states_e)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       start_v_i,
    output logic                                       start_ready_o,
    input  logic [lce_id_width_p-1:0]                  req_lce_i,
    input  logic                                       req_type_flag_i,
    input  logic                                       lru_dirty_flag_i,
    input  logic                                       lru_cached_excl_flag_i,
    input  logic                                       coh_mode_i,
    input  logic                                       dir_v_i,
    output logic                                       dir_ready_o,
    input  logic [lces_per_beat_p-1:0]                 dir_hits_i,
    input  logic [lces_per_beat_p*lg_lce_assoc_lp-1:0] dir_ways_i,
    input  logic [lces_per_beat_p*coh_w_lp-1:0]        dir_states_i,
    output logic                                       result_v_o,
    input  logic                                       result_yumi_i,
    output logic [lg_lce_assoc_lp-1:0]                 req_addr_way_o,
    output logic [lg_lce_assoc_lp-1:0]                 owner_way_o,
    output logic [lce_id_width_p-1:0]                  owner_lce_o,
    output logic [num_lce_p-1:0]                       inv_vec_o,
    output logic [cnt_w_lp-1:0]                        sharer_count_o,
    output logic                                       transfer_flag_o,
    output logic                                       replacement_flag_o,
    output logic                                       upgrade_flag_o,
    output logic                                       invalidate_flag_o,
    output logic                                       downgrade_flag_o,
    output logic                                       cached_flag_o,
    output logic                                       cached_exclusive_flag_o,
    output logic                                       cached_owned_flag_o,
    output logic                                       cached_dirty_flag_o
);

    bp_cce_gad_state_e state_r, state_n;

    logic [lg_beats_lp-1:0]                 beat_r;
    logic [lce_id_width_p-1:0]              req_lce_r;
    logic                                   wr_r, lru_dirty_r, lru_excl_r;
    bp_cce_coh_mode_e                       mode_r;
    logic [num_lce_p-1:0]                   hit_r;
    logic [num_lce_p*lg_lce_assoc_lp-1:0]   ways_r;
    logic [num_lce_p*coh_w_lp-1:0]          states_r;

    logic                                   start_fire, beat_fire, last_beat, compute;

    logic [lg_lce_assoc_lp-1:0] f_req_addr_way, f_owner_way;
    logic [lce_id_width_p-1:0]  f_owner_lce;
    logic [num_lce_p-1:0]       f_inv_vec;
    logic [cnt_w_lp-1:0]        f_sharer_count;
    logic f_transfer, f_replacement, f_upgrade, f_invalidate, f_downgrade;
    logic f_cached, f_cached_excl, f_cached_owned, f_cached_dirty;

    assign start_fire = (state_r == S_IDLE) && start_v_i;
    assign beat_fire  = (state_r == S_ACCUM) && dir_v_i;
    assign last_beat  = (beat_r == lg_beats_lp'(num_beats_lp - 1));
    assign compute    = (state_r == S_COMPUTE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= S_IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE:    if (start_v_i)              state_n = S_ACCUM;
            S_ACCUM:   if (dir_v_i && last_beat)   state_n = S_COMPUTE;
            S_COMPUTE:                             state_n = S_DONE;
            S_DONE:    if (result_yumi_i)          state_n = S_IDLE;
            default:                               state_n = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready_o = (state_r == S_IDLE);
        dir_ready_o   = (state_r == S_ACCUM);
        result_v_o    = (state_r == S_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_r      <= '0;
            req_lce_r   <= '0;
            wr_r        <= 1'b0;
            lru_dirty_r <= 1'b0;
            lru_excl_r  <= 1'b0;
            mode_r      <= e_coh_mesi;
            hit_r       <= '0;
            ways_r      <= '0;
            states_r    <= '0;
        end else begin
            if (start_fire) begin
                beat_r      <= '0;
                req_lce_r   <= req_lce_i;
                wr_r        <= (req_type_flag_i == e_lce_req_type_wr);
                lru_dirty_r <= lru_dirty_flag_i;
                lru_excl_r  <= lru_cached_excl_flag_i;
                mode_r      <= bp_cce_coh_mode_e'(coh_mode_i);
            end
            if (beat_fire) begin
                hit_r[beat_r*lces_per_beat_p +: lces_per_beat_p]                     <= dir_hits_i;
                ways_r[beat_r*lces_per_beat_p*lg_lce_assoc_lp +: lces_per_beat_p*lg_lce_assoc_lp] <= dir_ways_i;
                states_r[beat_r*lces_per_beat_p*coh_w_lp +: lces_per_beat_p*coh_w_lp] <= dir_states_i;
                beat_r <= beat_r + lg_beats_lp'(1);
            end
        end
    end

    bp_cce_gad_pipe_flags #(
        .num_lce_p      (num_lce_p),
        .lce_assoc_p    (lce_assoc_p),
        .lce_id_width_p (lce_id_width_p)
    ) flags (
        .hit              (hit_r),
        .ways             (ways_r),
        .states           (states_r),
        .req_lce          (req_lce_r),
        .wr               (wr_r),
        .lru_dirty        (lru_dirty_r),
        .lru_excl         (lru_excl_r),
        .moesif           (mode_r == e_coh_moesif),
        .req_addr_way     (f_req_addr_way),
        .owner_way        (f_owner_way),
        .owner_lce        (f_owner_lce),
        .inv_vec          (f_inv_vec),
        .sharer_count     (f_sharer_count),
        .transfer         (f_transfer),
        .replacement      (f_replacement),
        .upgrade          (f_upgrade),
        .invalidate       (f_invalidate),
        .downgrade        (f_downgrade),
        .cached           (f_cached),
        .cached_exclusive (f_cached_excl),
        .cached_owned     (f_cached_owned),
        .cached_dirty     (f_cached_dirty)
    );

    // Outputs only change in the single compute cycle, so they stay stable through S_DONE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_addr_way_o          <= '0;
            owner_way_o             <= '0;
            owner_lce_o             <= '0;
            inv_vec_o               <= '0;
            sharer_count_o          <= '0;
            transfer_flag_o         <= 1'b0;
            replacement_flag_o      <= 1'b0;
            upgrade_flag_o          <= 1'b0;
            invalidate_flag_o       <= 1'b0;
            downgrade_flag_o        <= 1'b0;
            cached_flag_o           <= 1'b0;
            cached_exclusive_flag_o <= 1'b0;
            cached_owned_flag_o     <= 1'b0;
            cached_dirty_flag_o     <= 1'b0;
        end else if (compute) begin
            req_addr_way_o          <= f_req_addr_way;
            owner_way_o             <= f_owner_way;
            owner_lce_o             <= f_owner_lce;
            inv_vec_o               <= f_inv_vec;
            sharer_count_o          <= f_sharer_count;
            transfer_flag_o         <= f_transfer;
            replacement_flag_o      <= f_replacement;
            upgrade_flag_o          <= f_upgrade;
            invalidate_flag_o       <= f_invalidate;
            downgrade_flag_o        <= f_downgrade;
            cached_flag_o           <= f_cached;
            cached_exclusive_flag_o <= f_cached_excl;
            cached_owned_flag_o     <= f_cached_owned;
            cached_dirty_flag_o     <= f_cached_dirty;
        end
    end

endmodule

`default_nettype wire
